// File: rtl/compare_tally_if.sv
// Handshake and result bundle between a comparator-flag source and compare_tally.
// The master drives Start, In_valid and the three flags; the slave returns status and tallies.
interface compare_tally_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             in_valid;
  logic             a_grt_b;
  logic             a_ls_b;
  logic             a_eq_b;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] grt_count;
  logic [CNT_W-1:0] ls_count;
  logic [CNT_W-1:0] eq_count;
  logic [1:0]       result;
  logic             err;

  modport master (
    output start, in_valid, a_grt_b, a_ls_b, a_eq_b,
    input  in_ready, busy, done, grt_count, ls_count, eq_count, result, err
  );

  modport slave (
    input  start, in_valid, a_grt_b, a_ls_b, a_eq_b,
    output in_ready, busy, done, grt_count, ls_count, eq_count, result, err
  );
endinterface

// File: rtl/compare_tally.sv
// Tallies WINDOW accepted comparator flag sets, flags non-one-hot sets and reports the majority.
// Handshake: a flag set transfers on any rising edge where in_valid and in_ready are both high.
module compare_tally #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  compare_tally_if.slave  bus,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] grt_q, grt_d;
  logic [CNT_W-1:0] ls_q, ls_d;
  logic [CNT_W-1:0] eq_q, eq_d;
  logic [CNT_W-1:0] smp_q, smp_d;
  logic [1:0]       result_q, result_d;
  logic             err_q, err_d;

  logic       accept;
  logic       last;
  logic [2:0] flags;

  // A code wins only with a strict maximum; any tie, including all-zero, yields 00.
  function automatic logic [1:0] majority(input logic [CNT_W-1:0] g,
                                          input logic [CNT_W-1:0] l,
                                          input logic [CNT_W-1:0] e);
    if (g > l && g > e)      return 2'b01;
    else if (l > g && l > e) return 2'b10;
    else if (e > g && e > l) return 2'b11;
    else                     return 2'b00;
  endfunction

  assign flags  = {bus.a_grt_b, bus.a_ls_b, bus.a_eq_b};
  assign accept = bus.in_valid && (state_q == COLLECT);
  assign last   = accept && (smp_q == CNT_W'(WINDOW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = COLLECT;
      COLLECT: if (last)      state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == COLLECT);
    bus.busy     = (state_q == COLLECT) || (state_q == DONE);
    bus.done     = (state_q == DONE);
    state_o      = state_q;
  end

  // Malformed sets still consume a window slot but leave every count untouched.
  always_comb begin
    grt_d    = grt_q;
    ls_d     = ls_q;
    eq_d     = eq_q;
    smp_d    = smp_q;
    result_d = result_q;
    err_d    = err_q;
    if (state_q == IDLE && bus.start) begin
      grt_d    = '0;
      ls_d     = '0;
      eq_d     = '0;
      smp_d    = '0;
      result_d = 2'b00;
      err_d    = 1'b0;
    end else if (accept) begin
      smp_d = smp_q + CNT_W'(1);
      case (flags)
        3'b100:  grt_d = grt_q + CNT_W'(1);
        3'b010:  ls_d  = ls_q + CNT_W'(1);
        3'b001:  eq_d  = eq_q + CNT_W'(1);
        default: err_d = 1'b1;
      endcase
      if (last) result_d = majority(grt_d, ls_d, eq_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grt_q    <= '0;
      ls_q     <= '0;
      eq_q     <= '0;
      smp_q    <= '0;
      result_q <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      grt_q    <= grt_d;
      ls_q     <= ls_d;
      eq_q     <= eq_d;
      smp_q    <= smp_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.grt_count = grt_q;
  assign bus.ls_count  = ls_q;
  assign bus.eq_count  = eq_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_compare_tally.sv
// Directed bench for compare_tally with WINDOW=8: reset, majority, tie, malformed flags and stalls.
module tb_compare_tally;
  localparam int WINDOW = 8;
  localparam int CNT_W  = 4;
  localparam int W      = 3 * CNT_W + 3;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_o;
  int         n_tests;
  int         n_fail;
  logic [W-1:0] exp_q[$];

  compare_tally_if #(.CNT_W(CNT_W)) bus ();

  compare_tally #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [2:0] f);
    bus.a_grt_b = f[2];
    bus.a_ls_b  = f[1];
    bus.a_eq_b  = f[0];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'(S_IDLE));
    chk({tag, "_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk({tag, "_cnts"},  32'({bus.grt_count, bus.ls_count, bus.eq_count}), 0);
    chk({tag, "_res"},   32'(bus.result), 0);
    chk({tag, "_err"},   32'(bus.err), 0);
  endtask

  // One full run; sample i is pat[3*i +: 3]. Start is raised together with an
  // in_valid carrying 111, which must not be accepted because in_ready is low in IDLE.
  task automatic run(input string tag, input logic [23:0] pat,
                     input logic [CNT_W-1:0] eg, input logic [CNT_W-1:0] el,
                     input logic [CNT_W-1:0] ee, input logic [1:0] er, input logic eerr);
    logic [W-1:0] exp_v;
    exp_q.push_back({eg, el, ee, er, eerr});
    bus.start = 1'b1; bus.in_valid = 1'b1; set_flags(3'b111);
    cyc();
    bus.start = 1'b0;
    chk({tag, "_collect"}, 32'(state_o), 32'(S_COLLECT));
    chk({tag, "_ready"},   32'(bus.in_ready), 1);
    chk({tag, "_cleared"}, 32'({bus.grt_count, bus.ls_count, bus.eq_count, bus.err}), 0);
    for (int i = 0; i < WINDOW; i++) begin
      bus.in_valid = 1'b1;
      set_flags(pat[3*i +: 3]);
      cyc();
      if (i < WINDOW - 1) chk({tag, "_no_early_done"}, 32'(bus.done), 0);
    end
    bus.in_valid = 1'b0;
    chk({tag, "_done"},  32'(bus.done), 1);
    chk({tag, "_busy"},  32'(bus.busy), 1);
    chk({tag, "_ready_in_done"}, 32'(bus.in_ready), 0);
    exp_v = exp_q.pop_front();
    chk({tag, "_tally"}, 32'({bus.grt_count, bus.ls_count, bus.eq_count, bus.result, bus.err}),
        32'(exp_v));
    cyc();
    chk({tag, "_idle"}, 32'(state_o), 32'(S_IDLE));
    chk({tag, "_pulse_end"}, 32'(bus.done), 0);
    chk({tag, "_hold"}, 32'({bus.grt_count, bus.ls_count, bus.eq_count, bus.result, bus.err}),
        32'({eg, el, ee, er, eerr}));
  endtask

  int   acc;
  int   done_cnt;
  logic seen;

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; set_flags(3'b000);
    cyc(); cyc();
    chk_clear("reset");
    rst_n = 1'b1;
    cyc();

    // Reset mid-run: abort after three accepted 100 samples
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("mid_collect", 32'(state_o), 32'(S_COLLECT));
    bus.in_valid = 1'b1; set_flags(3'b100);
    cyc(); cyc(); cyc();
    chk("mid_grt3", 32'(bus.grt_count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk_clear("async_rst");
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_ignored", 32'({state_o, bus.grt_count, bus.in_ready}), 0);
    end
    bus.in_valid = 1'b0;
    cyc();

    run("majority",  {{3{3'b010}}, {5{3'b100}}},     4'd5, 4'd3, 4'd0, 2'b01, 1'b0);
    run("tie",       {{4{3'b001}}, {4{3'b010}}},     4'd0, 4'd4, 4'd4, 2'b00, 1'b0);
    run("malformed", {3'b000, 3'b110, {6{3'b001}}},  4'd0, 4'd0, 4'd6, 2'b11, 1'b1);

    // Stall with Start held high throughout; 001 on every valid cycle
    bus.start = 1'b1; bus.in_valid = 1'b0; set_flags(3'b001);
    cyc();
    chk("stall_collect", 32'(state_o), 32'(S_COLLECT));
    chk("stall_err_cleared", 32'(bus.err), 0);
    acc = 0; done_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      bus.in_valid = (i % 2 == 0);
      cyc();
      if (bus.in_valid) acc++;
      if (bus.done) begin
        done_cnt++;
        seen = 1'b1;
      end else begin
        chk("stall_eq_track", 32'(bus.eq_count), 32'(acc));
      end
    end
    bus.in_valid = 1'b0;
    chk("stall_done_seen", 32'(seen), 1);
    chk("stall_eq8", 32'(bus.eq_count), 8);
    chk("stall_res", 32'(bus.result), 32'(2'b11));
    cyc();
    if (bus.done) done_cnt++;
    chk("stall_start_in_done_ignored", 32'(state_o), 32'(S_IDLE));
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus.done) done_cnt++;
      chk("stall_hold", 32'({state_o, bus.eq_count, bus.result, bus.err}),
          32'({S_IDLE, 4'd8, 2'b11, 1'b0}));
    end
    chk("stall_one_done", 32'(done_cnt), 1);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("restart_collect", 32'(state_o), 32'(S_COLLECT));
    chk("restart_clear", 32'({bus.grt_count, bus.ls_count, bus.eq_count, bus.result, bus.err}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/compare_tally.md
# compare_tally

Downstream consumer of the 4-bit magnitude comparator's flag outputs (greater / less / equal). Over a window of WINDOW accepted comparisons it counts each outcome and flags malformed (non-one-hot) flag sets. It reports the majority outcome and the three counts with a one-cycle Done pulse. The block is sequenced by a Start / In_valid / In_ready handshake so the upstream operand source can stall.

## Interface
- WINDOW, 8: number of accepted comparisons per tally run; legal range 1..255.
- CNT_W, $clog2(WINDOW+1): width of each count; must represent the value WINDOW.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset; one clock, no other clock domains.
- Start  in  1  begins a tally run; sampled only in IDLE.
- In_valid  in  1  comparator flags on A_grt_B/A_ls_B/A_eq_B are valid this cycle.
- A_grt_B  in  1  comparator "A greater than B" flag.
- A_ls_B  in  1  comparator "A less than B" flag.
- A_eq_B  in  1  comparator "A equal to B" flag.
- In_ready  out  1  block accepts a flag set this cycle (high only in COLLECT).
- Busy  out  1  high in COLLECT and DONE.
- Done  out  1  one-cycle pulse when a run completes.
- Grt_count  out  CNT_W  accepted samples with only A_grt_B high.
- Ls_count  out  CNT_W  accepted samples with only A_ls_B high.
- Eq_count  out  CNT_W  accepted samples with only A_eq_B high.
- Result  out  2  majority: 01 greater, 10 less, 11 equal, 00 tie or no valid samples.
- Err  out  1  sticky: at least one accepted sample in this run was not one-hot.

## Operation
- States: IDLE, COLLECT, DONE; encoded as registered state, reset to IDLE.
- IDLE:
  - In_ready=0, Busy=0.
  - On Start=1: clear all counts, the sample counter, Err and Result; next state COLLECT.
- COLLECT:
  - In_ready=1, Busy=1.
  - Accept = In_valid & In_ready.
  - On accept of a one-hot flag set, increment the matching count by 1.
  - On accept of a non-one-hot set (000, or two or more flags high), set Err. No count changes, but the sample still consumes a window slot.
  - Sample counter increments on every accept. The accept that brings it to WINDOW moves the state to DONE.
  - Start is ignored in COLLECT.
- DONE:
  - Done=1 and Busy=1 for exactly one cycle, then IDLE.
  - In_ready=0.
  - Start in DONE is ignored; a new run requires Start in IDLE.
- Result:
  - Registered on the transition into DONE and computed from the final counts.
  - A code is chosen only if its count is strictly greater than both others; any tie for the maximum gives 00.
- Counts, Result and Err hold their values from DONE until the next Start in IDLE.
- Arithmetic:
  - Counts are unsigned CNT_W bits.
  - Grt_count + Ls_count + Eq_count ≤ WINDOW always; no wrap is possible.
  - Sample counter is the same width as the counts.

## Timing
- Reset (Reset=0, asynchronous): state=IDLE, In_ready=0, Busy=0, Done=0, all counts=0, Result=00, Err=0. This holds regardless of the clock and aborts any run mid-window.
- Start sampled high in IDLE at edge k: state is COLLECT and In_ready=1 in cycle k+1.
- Accept at edge m: the counts reflect that sample from cycle m+1.
- WINDOW-th accept at edge n: Done=1 with final counts and Result valid in cycle n+1; IDLE in cycle n+2.
- Minimum run length is WINDOW+2 cycles after Start, with In_valid held high.
- In_valid low in COLLECT stalls the run with no timeout; state and counts are held.
- Start and In_valid high together in IDLE: Start is taken; In_valid is not accepted, because In_ready=0 that cycle.

## Test plan
- Reset mid-run: WINDOW=8, Start, 3 accepts of 100, then Reset low for one cycle. Required: all outputs 0 and state IDLE immediately; 3 further In_valid cycles are not accepted.
- Clear majority: Start, then 8 back-to-back accepts of 5×100 and 3×010. Required: Done pulse 9 cycles after the Start edge, Grt_count=5, Ls_count=3, Eq_count=0, Result=01, Err=0.
- Tie: 4×010 and 4×001. Required: Ls_count=4, Eq_count=4, Result=00, Err=0.
- Malformed flags: 6×001, 1×110, 1×000. Required: Eq_count=6, Grt_count=0, Ls_count=0, Err=1, Result=11, Done after 8 accepts.
- Stall and ignored Start: In_valid toggles 1-0-1 with Start held high throughout, 8 accepts total of 001. Required:
  - Eq_count=8 and exactly one Done pulse.
  - Outputs hold in the following IDLE until Start.
  - A second Start clears the counts to 0 in the next cycle.
